// File: rtl/invader_draw_scheduler.sv
// invader_draw_scheduler: alien/shot tick generation, row counters and arbitration of the single VGA plotter.
// Optional macro SCHED_FAST_SIM_EN shrinks the alien/shot tick reloads to 63/7 for simulation.
module invader_draw_scheduler #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned ALIEN_PERIOD_S  = 4,
  parameter int unsigned SHOT_RATE_HZ    = 3,
  parameter int unsigned ALIEN_FLOOR     = 40,
  parameter int unsigned SHOT_START_Y    = 110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drewHomeBase,
  input  logic       fire,
  input  logic [7:0] fire_x,
  input  logic       hit,
  output logic       plot_req,
  output logic       plot_obj,
  output logic       plot_erase,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  input  logic       plot_done,
  output logic [5:0] alien_y,
  output logic [6:0] shot_y,
  output logic       shot_active,
  output logic       gameOver
);

  localparam int unsigned TICK_W = 32;
`ifdef SCHED_FAST_SIM_EN
  localparam logic [TICK_W-1:0] ALIEN_RELOAD = TICK_W'(63);
  localparam logic [TICK_W-1:0] SHOT_RELOAD  = TICK_W'(7);
`else
  localparam logic [TICK_W-1:0] ALIEN_RELOAD = TICK_W'(CLOCK_FREQUENCY * ALIEN_PERIOD_S - 1);
  localparam logic [TICK_W-1:0] SHOT_RELOAD  = TICK_W'(CLOCK_FREQUENCY / SHOT_RATE_HZ - 1);
`endif

  typedef enum logic [2:0] {IDLE, RUN, ERASE, DRAW, OVER} state_t;
  typedef enum logic [1:0] {JOB_KILL, JOB_ALIEN, JOB_LAUNCH, JOB_SHOT} job_t;

  state_t state, state_n;
  job_t   job, job_n;
  logic   sel;
  logic   txn_done;

  logic [TICK_W-1:0] alien_cnt, shot_cnt;
  logic              alien_pend, shot_pend, launch_pend, kill_pend;
  logic [7:0]        shot_x;

  logic run, in_txn, in_txn_n;
  logic alien_tick, shot_tick, fire_ok, hit_ok;
  logic erase_done, shot_off;

  assign run        = (state == RUN) || (state == ERASE) || (state == DRAW);
  assign in_txn     = (state == ERASE) || (state == DRAW);
  assign in_txn_n   = (state_n == ERASE) || (state_n == DRAW);
  assign alien_tick = run && (alien_cnt == '0);
  assign shot_tick  = run && shot_active && (shot_cnt == '0);
  assign fire_ok    = run && fire && !shot_active;
  assign hit_ok     = run && hit && shot_active;
  assign erase_done = (state == ERASE) && txn_done;
  assign shot_off   = erase_done && ((job == JOB_KILL) || ((job == JOB_SHOT) && (shot_y == 7'd0)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      job   <= JOB_KILL;
    end else begin
      state <= state_n;
      job   <= job_n;
    end
  end

  // Next state and job selection; priority kill > alien > launch > shot
  always_comb begin
    state_n  = state;
    job_n    = job;
    sel      = 1'b0;
    txn_done = plot_req && plot_done;
    unique case (state)
      IDLE: if (drewHomeBase) state_n = RUN;
      RUN: begin
        if (kill_pend) begin
          job_n = JOB_KILL;   state_n = ERASE; sel = 1'b1;
        end else if (alien_pend) begin
          job_n = JOB_ALIEN;  state_n = ERASE; sel = 1'b1;
        end else if (launch_pend) begin
          job_n = JOB_LAUNCH; state_n = DRAW;  sel = 1'b1;
        end else if (shot_pend) begin
          job_n = JOB_SHOT;   state_n = ERASE; sel = 1'b1;
        end
      end
      ERASE: begin
        if (txn_done) begin
          if ((job == JOB_KILL) || ((job == JOB_SHOT) && (shot_y == 7'd0))) state_n = RUN;
          else                                                             state_n = DRAW;
        end
      end
      DRAW: begin
        if (txn_done) begin
          if ((job == JOB_ALIEN) && (alien_y == 6'(ALIEN_FLOOR))) state_n = OVER;
          else                                                    state_n = RUN;
        end
      end
      OVER:    state_n = OVER;
      default: state_n = IDLE;
    endcase
  end

  // Tick counters hold at reload outside active play
  always_ff @(posedge clk) begin
    if (reset) begin
      alien_cnt <= ALIEN_RELOAD;
      shot_cnt  <= SHOT_RELOAD;
    end else begin
      if (!run || (alien_cnt == '0)) alien_cnt <= ALIEN_RELOAD;
      else                           alien_cnt <= alien_cnt - TICK_W'(1);
      if (!run || !shot_active || (shot_cnt == '0)) shot_cnt <= SHOT_RELOAD;
      else                                          shot_cnt <= shot_cnt - TICK_W'(1);
    end
  end

  // Sticky pending flags; shot-related flags are flushed once the shot leaves play
  always_ff @(posedge clk) begin
    if (reset) begin
      alien_pend  <= 1'b0;
      shot_pend   <= 1'b0;
      launch_pend <= 1'b0;
      kill_pend   <= 1'b0;
    end else begin
      if (!run)                               alien_pend <= 1'b0;
      else if (alien_tick)                    alien_pend <= 1'b1;
      else if (sel && (job_n == JOB_ALIEN))   alien_pend <= 1'b0;

      if (!run || shot_off || hit_ok)         shot_pend <= 1'b0;
      else if (shot_tick)                     shot_pend <= 1'b1;
      else if (sel && (job_n == JOB_SHOT))    shot_pend <= 1'b0;

      if (!run || shot_off || hit_ok)         launch_pend <= 1'b0;
      else if (fire_ok)                       launch_pend <= 1'b1;
      else if (sel && (job_n == JOB_LAUNCH))  launch_pend <= 1'b0;

      if (!run || shot_off)                   kill_pend <= 1'b0;
      else if (hit_ok)                        kill_pend <= 1'b1;
      else if (sel && (job_n == JOB_KILL))    kill_pend <= 1'b0;
    end
  end

  // Row counters and shot state; rows advance on the completing erase edge
  always_ff @(posedge clk) begin
    if (reset) begin
      alien_y     <= '0;
      shot_y      <= '0;
      shot_x      <= '0;
      shot_active <= 1'b0;
    end else begin
      if (erase_done && (job == JOB_ALIEN)) alien_y <= alien_y + 6'd1;
      if (fire_ok) begin
        shot_active <= 1'b1;
        shot_y      <= 7'(SHOT_START_Y);
        shot_x      <= fire_x;
      end else begin
        if (shot_off) shot_active <= 1'b0;
        if (erase_done && (job == JOB_SHOT) && (shot_y != 7'd0)) shot_y <= shot_y - 7'd1;
      end
    end
  end

  // Plotter request and payload; req rises one cycle after entering ERASE/DRAW
  always_ff @(posedge clk) begin
    if (reset) begin
      plot_req   <= 1'b0;
      plot_obj   <= 1'b0;
      plot_erase <= 1'b0;
      plot_x     <= '0;
      plot_y     <= '0;
      gameOver   <= 1'b0;
    end else begin
      plot_req <= in_txn_n && (state_n == state);
      if (in_txn) begin
        plot_obj   <= (job != JOB_ALIEN);
        plot_erase <= (state == ERASE);
        plot_x     <= (job == JOB_ALIEN) ? 8'd0 : shot_x;
        plot_y     <= (job == JOB_ALIEN) ? {1'b0, alien_y} : shot_y;
      end
      if (state_n == OVER) gameOver <= 1'b1;
    end
  end

endmodule

// File: tb/tb_invader_draw_scheduler.sv
// Directed bench for invader_draw_scheduler; parameters chosen so reloads are 63 (alien) and 7 (shot).
module tb_invader_draw_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       drewHomeBase = 1'b0;
  logic       fire = 1'b0;
  logic [7:0] fire_x = 8'd0;
  logic       hit = 1'b0;
  logic       plot_req;
  logic       plot_obj;
  logic       plot_erase;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic       plot_done = 1'b1;
  logic [5:0] alien_y;
  logic [6:0] shot_y;
  logic       shot_active;
  logic       gameOver;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  invader_draw_scheduler #(
    .CLOCK_FREQUENCY(16),
    .ALIEN_PERIOD_S (4),
    .SHOT_RATE_HZ   (2),
    .ALIEN_FLOOR    (40),
    .SHOT_START_Y   (110)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .drewHomeBase(drewHomeBase),
    .fire        (fire),
    .fire_x      (fire_x),
    .hit         (hit),
    .plot_req    (plot_req),
    .plot_obj    (plot_obj),
    .plot_erase  (plot_erase),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_done   (plot_done),
    .alien_y     (alien_y),
    .shot_y      (shot_y),
    .shot_active (shot_active),
    .gameOver    (gameOver)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!plot_req && (n < budget));
    check({tag, "_req"}, 32'(plot_req), 32'd1);
  endtask

  task automatic check_txn(input string tag, input logic obj, input logic er,
                           input logic [7:0] x, input logic [6:0] y);
    check({tag, "_obj"},   32'(plot_obj),   32'(obj));
    check({tag, "_erase"}, 32'(plot_erase), 32'(er));
    check({tag, "_x"},     32'(plot_x),     32'(x));
    check({tag, "_y"},     32'(plot_y),     32'(y));
  endtask

  initial begin
    int n;
    int t_prev;
    int diffs;
    int reqs;
    logic [6:0] last_draw_y;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req",    32'(plot_req),    32'd0);
    check("rst_alien",  32'(alien_y),     32'd0);
    check("rst_shot_y", 32'(shot_y),      32'd0);
    check("rst_active", 32'(shot_active), 32'd0);
    check("rst_over",   32'(gameOver),    32'd0);
    check("rst_plot_y", 32'(plot_y),      32'd0);

    // Start game: first alien erase/draw pair
    reset = 1'b0;
    drewHomeBase = 1'b1;
    @(negedge clk);
    drewHomeBase = 1'b0;
    wait_req("first", 200, n);
    check("first_lat", 32'(n), 32'd66);
    check_txn("a0_erase", 1'b0, 1'b1, 8'h00, 7'd0);
    @(negedge clk);
    check("a0_gap", 32'(plot_req), 32'd0);
    check("a0_alien_y", 32'(alien_y), 32'd1);
    wait_req("a0d", 10, n);
    check_txn("a0_draw", 1'b0, 1'b0, 8'h00, 7'd1);
    @(negedge clk);

    // Launch: draw-only at the start row
    fire = 1'b1;
    fire_x = 8'h55;
    @(negedge clk);
    fire = 1'b0;
    wait_req("launch", 20, n);
    check("launch_lat", 32'(n), 32'd2);
    check_txn("launch", 1'b1, 1'b0, 8'h55, 7'd110);
    check("launch_active", 32'(shot_active), 32'd1);
    @(negedge clk);

    // Second fire while in flight is ignored
    fire = 1'b1;
    fire_x = 8'h22;
    @(negedge clk);
    fire = 1'b0;
    check("refire_y", 32'(shot_y), 32'd110);

    // Shot rise: erase/draw pairs every 8 cycles
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_req("shot_e", 30, n);
      check_txn("shot_erase", 1'b1, 1'b1, 8'h55, 7'(110 - i));
      if (i > 0) check("shot_period", 32'(cyc - t_prev), 32'd8);
      t_prev = cyc;
      wait_req("shot_d", 10, n);
      check_txn("shot_draw", 1'b1, 1'b0, 8'h55, 7'(109 - i));
    end

    // Hit during a shot draw: draw finishes, then kill erase, no redraw
    wait_req("hit_e", 30, n);
    check_txn("hit_pre_erase", 1'b1, 1'b1, 8'h55, 7'd107);
    wait_req("hit_d", 10, n);
    check_txn("hit_draw", 1'b1, 1'b0, 8'h55, 7'd106);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    check("hit_draw_done", 32'(plot_req), 32'd0);
    wait_req("kill", 10, n);
    check_txn("kill_erase", 1'b1, 1'b1, 8'h55, 7'd106);
    @(negedge clk);
    check("kill_inactive", 32'(shot_active), 32'd0);
    reqs = 0;
    repeat (8) begin
      @(negedge clk);
      if (plot_req) reqs++;
    end
    check("kill_no_draw", 32'(reqs), 32'd0);

    // Next alien step
    wait_req("a1e", 40, n);
    check_txn("a1_erase", 1'b0, 1'b1, 8'h00, 7'd1);
    wait_req("a1d", 10, n);
    check_txn("a1_draw", 1'b0, 1'b0, 8'h00, 7'd2);
    @(negedge clk);

    // Stalled launch draw while alien and shot ticks both go pending
    fire = 1'b1;
    fire_x = 8'h3c;
    @(negedge clk);
    fire = 1'b0;
    wait_req("launch2", 20, n);
    plot_done = 1'b0;
    check_txn("launch2", 1'b1, 1'b0, 8'h3c, 7'd110);
    diffs = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!plot_req || !plot_obj || plot_erase || (plot_x != 8'h3c) || (plot_y != 7'd110)) diffs++;
    end
    check("stall_stable", 32'(diffs), 32'd0);
    plot_done = 1'b1;
    wait_req("pri_a_e", 20, n);
    check_txn("pri_alien_erase", 1'b0, 1'b1, 8'h00, 7'd2);
    wait_req("pri_a_d", 10, n);
    check_txn("pri_alien_draw", 1'b0, 1'b0, 8'h00, 7'd3);
    wait_req("pri_s_e", 10, n);
    check_txn("pri_shot_erase", 1'b1, 1'b1, 8'h3c, 7'd110);
    wait_req("pri_s_d", 10, n);
    check_txn("pri_shot_draw", 1'b1, 1'b0, 8'h3c, 7'd109);

    // Descend to the floor
    last_draw_y = 7'd0;
    n = 0;
    while (!gameOver && (n < 6000)) begin
      @(negedge clk);
      n++;
      if (plot_req && !plot_obj && !plot_erase) last_draw_y = plot_y;
    end
    check("game_over", 32'(gameOver), 32'd1);
    check("floor_draw_y", 32'(last_draw_y), 32'd40);
    check("floor_alien_y", 32'(alien_y), 32'd40);
    check("over_shot_done", 32'(shot_active), 32'd0);

    // OVER ignores fire and issues no plots
    reqs = 0;
    for (int i = 0; i < 100; i++) begin
      fire = ~fire;
      fire_x = 8'(i);
      @(negedge clk);
      if (plot_req) reqs++;
    end
    fire = 1'b0;
    check("over_no_req", 32'(reqs), 32'd0);
    check("over_no_shot", 32'(shot_active), 32'd0);
    check("over_sticky", 32'(gameOver), 32'd1);

    // Reset in the middle of a stalled transaction
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drewHomeBase = 1'b1;
    @(negedge clk);
    drewHomeBase = 1'b0;
    wait_req("re_first", 200, n);
    check_txn("re_erase", 1'b0, 1'b1, 8'h00, 7'd0);
    plot_done = 1'b0;
    @(negedge clk);
    check("re_held", 32'(plot_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_req",    32'(plot_req),    32'd0);
    check("mid_rst_alien",  32'(alien_y),     32'd0);
    check("mid_rst_over",   32'(gameOver),    32'd0);
    check("mid_rst_active", 32'(shot_active), 32'd0);
    reset = 1'b0;
    plot_done = 1'b1;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (plot_req) reqs++;
    end
    check("idle_no_req", 32'(reqs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
